// File: rtl/pixel_comp_pkg.sv
// Shared types and colour constants for the pixel compositor and its game-state FSM.
package pixel_comp_pkg;

  // Frame-synchronous game state; encoding is visible on the game_state port.
  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    FLASH = 2'd1,
    OVER  = 2'd2
  } game_state_t;

  // Text colour class; class 3 renders like white.
  typedef enum logic [1:0] {
    TXT_WHITE     = 2'd0,
    TXT_YELLOW    = 2'd1,
    TXT_RED       = 2'd2,
    TXT_WHITE_ALT = 2'd3
  } text_class_t;

  // Winning layer carried from the priority stage to the modulation stage.
  typedef enum logic [2:0] {
    LAYER_BG     = 3'd0,
    LAYER_SPRITE = 3'd1,
    LAYER_WALL   = 3'd2,
    LAYER_FOOD   = 3'd3,
    LAYER_TEXT   = 3'd4
  } layer_id_t;

  // Fixed palette as {R,G,B} channel masks; each set bit expands to an
  // all-ones channel of CW bits inside the compositor.
  localparam logic [2:0] WALL_BLUE = 3'b001;
  localparam logic [2:0] WHITE     = 3'b111;
  localparam logic [2:0] YELLOW    = 3'b110;
  localparam logic [2:0] RED       = 3'b100;
  localparam logic [2:0] BLACK     = 3'b000;

endpackage

// File: rtl/game_flash_fsm.sv
// Frame-synchronous game-state machine: PLAY -> collision FLASH -> OVER, restart back to PLAY.
module game_flash_fsm
  import pixel_comp_pkg::*;
#(
  parameter int FLASH_PERIOD  = 8,
  parameter int FLASH_TOGGLES = 6
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_start,
  input  logic        collision,
  input  logic        restart,
  output game_state_t state,
  output logic        phase
);

  localparam int FCW = $clog2(FLASH_PERIOD) + 1;
  localparam int TCW = $clog2(FLASH_TOGGLES) + 1;
  localparam logic [FCW-1:0] FC_LAST = FCW'(FLASH_PERIOD - 1);
  localparam logic [TCW-1:0] TC_LAST = TCW'(FLASH_TOGGLES - 1);

  game_state_t    state_q, state_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic [TCW-1:0] toggle_cnt_q, toggle_cnt_d;
  logic           phase_q, phase_d;

  // State, counters and phase registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= PLAY;
      frame_cnt_q  <= '0;
      toggle_cnt_q <= '0;
      phase_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      toggle_cnt_q <= toggle_cnt_d;
      phase_q      <= phase_d;
    end
  end

  // Next-state logic; restart overrides any coincident frame event.
  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    toggle_cnt_d = toggle_cnt_q;
    phase_d      = phase_q;
    if (restart) begin
      state_d      = PLAY;
      frame_cnt_d  = '0;
      toggle_cnt_d = '0;
      phase_d      = 1'b0;
    end else begin
      case (state_q)
        PLAY: begin
          // Collision only counts at a frame boundary so a frame never tears.
          if (frame_start && collision) begin
            state_d      = FLASH;
            frame_cnt_d  = '0;
            toggle_cnt_d = '0;
            phase_d      = 1'b1;
          end else begin
            state_d = PLAY;
          end
        end
        FLASH: begin
          if (frame_start) begin
            if (frame_cnt_q == FC_LAST) begin
              if (toggle_cnt_q == TC_LAST) begin
                state_d     = OVER;
                frame_cnt_d = '0;
                phase_d     = 1'b0;
              end else begin
                frame_cnt_d  = '0;
                phase_d      = ~phase_q;
                toggle_cnt_d = toggle_cnt_q + TCW'(1);
              end
            end else begin
              frame_cnt_d = frame_cnt_q + FCW'(1);
            end
          end else begin
            state_d = FLASH;
          end
        end
        OVER: begin
          state_d = OVER;
        end
        default: begin
          state_d      = PLAY;
          frame_cnt_d  = '0;
          toggle_cnt_d = '0;
          phase_d      = 1'b0;
        end
      endcase
    end
  end

  assign state = state_q;
  assign phase = phase_q;

endmodule

// File: rtl/pixel_compositor.sv
// Two-stage per-pixel compositor: stage 1 resolves layer priority, stage 2 applies game-state colour modulation.
module pixel_compositor
  import pixel_comp_pkg::*;
#(
  parameter int NUM_SPRITES              = 4,
  parameter int CW                       = 8,
  parameter int FIELD_H                  = 352,
  parameter logic [3*CW-1:0] TRANSP_KEY  = 24'hFF00FF,
  parameter int FLASH_PERIOD             = 8,
  parameter int FLASH_TOGGLES            = 6
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          pix_valid,
  input  logic                          frame_start,
  input  logic [9:0]                    DrawX,
  input  logic [9:0]                    DrawY,
  input  logic [NUM_SPRITES-1:0]        sprite_hit,
  input  logic [NUM_SPRITES*3*CW-1:0]   sprite_rgb,
  input  logic                          is_wall,
  input  logic                          food_hit,
  input  logic                          text_hit,
  input  logic [1:0]                    text_class,
  input  logic                          collision,
  input  logic                          restart,
  output logic [CW-1:0]                 VGA_R,
  output logic [CW-1:0]                 VGA_G,
  output logic [CW-1:0]                 VGA_B,
  output logic                          out_valid,
  output logic [1:0]                    game_state
);

  localparam int PW = 3 * CW;
  localparam logic [10:0] FIELD_LIM = 11'(FIELD_H);

  // Expand a 3-bit {R,G,B} mask into full-width channels.
  function automatic logic [PW-1:0] expand(input logic [2:0] m);
    return {{CW{m[2]}}, {CW{m[1]}}, {CW{m[0]}}};
  endfunction

  // Halve each channel independently (truncating).
  function automatic logic [PW-1:0] dim(input logic [PW-1:0] c);
    return {(c[PW-1 -: CW] >> 1), (c[2*CW-1 -: CW] >> 1), (c[CW-1:0] >> 1)};
  endfunction

  game_state_t state_s;
  logic        phase_s;

  game_flash_fsm #(
    .FLASH_PERIOD (FLASH_PERIOD),
    .FLASH_TOGGLES(FLASH_TOGGLES)
  ) u_fsm (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_start(frame_start),
    .collision  (collision),
    .restart    (restart),
    .state      (state_s),
    .phase      (phase_s)
  );

  // Horizontal position does not affect colour resolution.
  logic unused_drawx_s;
  assign unused_drawx_s = ^DrawX;

  logic        spr_found_s;
  logic [PW-1:0] spr_sel_s;
  logic        in_field_s;

  layer_id_t   layer_q, layer_d;
  logic [PW-1:0] colour_q, colour_d;
  text_class_t tcls_q, tcls_d;
  logic        valid_q, valid_d;

  logic [PW-1:0] rgb_q, rgb_d;
  logic        out_valid_q, out_valid_d;

  // Priority encoder over sprites: lowest index with a non-keyed colour wins.
  always_comb begin
    spr_found_s = 1'b0;
    spr_sel_s   = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (!spr_found_s && sprite_hit[i] && (sprite_rgb[i*PW +: PW] != TRANSP_KEY)) begin
        spr_found_s = 1'b1;
        spr_sel_s   = sprite_rgb[i*PW +: PW];
      end else begin
        spr_found_s = spr_found_s;
      end
    end
  end

  assign in_field_s = ({1'b0, DrawY} < FIELD_LIM);

  // Stage-1 layer selection: sprite, wall, food, text, background.
  always_comb begin
    layer_d  = LAYER_BG;
    colour_d = '0;
    tcls_d   = TXT_WHITE;
    valid_d  = pix_valid;
    if (!pix_valid) begin
      layer_d = LAYER_BG;
    end else if (spr_found_s) begin
      layer_d  = LAYER_SPRITE;
      colour_d = spr_sel_s;
    end else if (is_wall && in_field_s) begin
      layer_d = LAYER_WALL;
    end else if (food_hit && in_field_s) begin
      layer_d = LAYER_FOOD;
    end else if (text_hit) begin
      layer_d = LAYER_TEXT;
      tcls_d  = text_class_t'(text_class);
    end else begin
      layer_d = LAYER_BG;
    end
  end

  // Stage-1 pipeline registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      layer_q  <= LAYER_BG;
      colour_q <= '0;
      tcls_q   <= TXT_WHITE;
      valid_q  <= 1'b0;
    end else begin
      layer_q  <= layer_d;
      colour_q <= colour_d;
      tcls_q   <= tcls_d;
      valid_q  <= valid_d;
    end
  end

  // Stage-2 colour modulation from the current game state and flash phase.
  always_comb begin
    rgb_d       = expand(BLACK);
    out_valid_d = valid_q;
    if (valid_q) begin
      case (layer_q)
        LAYER_SPRITE: begin
          if (state_s == OVER) begin
            rgb_d = dim(colour_q);
          end else begin
            rgb_d = colour_q;
          end
        end
        LAYER_WALL: begin
          if ((state_s == FLASH) && phase_s) begin
            rgb_d = expand(WHITE);
          end else begin
            rgb_d = expand(WALL_BLUE);
          end
        end
        LAYER_FOOD: begin
          rgb_d = expand(WHITE);
        end
        LAYER_TEXT: begin
          case (tcls_q)
            TXT_YELLOW: rgb_d = expand(YELLOW);
            TXT_RED: begin
              // Game-over text stays hidden during play.
              if (state_s == PLAY) begin
                rgb_d = expand(BLACK);
              end else begin
                rgb_d = expand(RED);
              end
            end
            default: rgb_d = expand(WHITE);
          endcase
        end
        default: begin
          rgb_d = expand(BLACK);
        end
      endcase
    end else begin
      rgb_d = expand(BLACK);
    end
  end

  // Stage-2 output registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rgb_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      rgb_q       <= rgb_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign VGA_R      = rgb_q[PW-1 -: CW];
  assign VGA_G      = rgb_q[2*CW-1 -: CW];
  assign VGA_B      = rgb_q[CW-1:0];
  assign out_valid  = out_valid_q;
  assign game_state = state_s;

endmodule
